// File: rtl/switch_accumulator.sv
// switch_accumulator: debounced accumulate/clear keys drive a wrap/saturate
// accumulator fed by the synchronised switch operand. Holding the accumulate
// key auto-repeats. The reset release is assumed to be already synchronous to
// clk_clk (it comes from the system reset controller), so no local reset
// synchroniser is added and the press latency stays DEB_CYCLES+3 edges.

// Key debouncer: IDLE/PRESS_DB/HELD/REPEAT/RELEASE_DB on a synchronised,
// active-low key. o_fire is a single-cycle strobe on acceptance of a press and,
// when REPEAT_EN is set, on every auto-repeat.
module switch_accumulator_key #(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_fire
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REPEAT,
    S_RELEASE_DB
  } key_state_t;

  localparam int REP_MAX_CNT = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int DEB_W       = $clog2(DEB_CYCLES + 1);
  localparam int REP_W       = $clog2(REP_MAX_CNT + 1);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REP_DELAY > 0) ? REP_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_CLAMP   = '1;
  // Repeat is active only for the instance that asks for it and a nonzero delay.
  localparam bit               REP_ON      = REPEAT_EN && (REP_DELAY > 0);

  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_fire;

  // State and counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_deb_cnt <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_rep_cnt <= w_rep_nxt;
    end
  end

  // Next-state, counter update and fire decode.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_deb_nxt = '0;
        w_rep_nxt = '0;
        if (!i_key_n) w_state_nxt = S_PRESS_DB;
      end
      S_PRESS_DB: begin
        if (i_key_n) begin
          w_state_nxt = S_IDLE;
          w_deb_nxt   = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = S_HELD;
          w_fire      = 1'b1;
          w_deb_nxt   = '0;
          w_rep_nxt   = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      S_HELD: begin
        if (i_key_n) begin
          w_state_nxt = S_RELEASE_DB;
          w_deb_nxt   = '0;
        end else if (REP_ON && (r_rep_cnt == DELAY_LAST)) begin
          w_state_nxt = S_REPEAT;
          w_fire      = 1'b1;
          w_rep_nxt   = '0;
        end else if (r_rep_cnt != REP_CLAMP) begin
          // Clamp rather than wrap while the key is held indefinitely.
          w_rep_nxt = r_rep_cnt + REP_W'(1);
        end
      end
      S_REPEAT: begin
        if (i_key_n) begin
          w_state_nxt = S_RELEASE_DB;
          w_deb_nxt   = '0;
        end else if (r_rep_cnt == PERIOD_LAST) begin
          w_fire    = 1'b1;
          w_rep_nxt = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + REP_W'(1);
        end
      end
      S_RELEASE_DB: begin
        if (!i_key_n) begin
          // Release was a bounce: back to HELD with a fresh repeat delay, no fire.
          w_state_nxt = S_HELD;
          w_deb_nxt   = '0;
          w_rep_nxt   = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = S_IDLE;
          w_deb_nxt   = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_deb_nxt   = '0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  assign o_fire = w_fire;

endmodule

// Top level: synchronisers, two key debouncers and the accumulator datapath.
module switch_accumulator #(
  parameter int SW_W       = 8,
  parameter int ACC_W      = 16,
  parameter int LED_W      = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [SW_W-1:0]  sw_in,
  input  logic             acc_key_n,
  input  logic             clr_key_n,
  input  logic             sub_mode,
  input  logic             sat_mode,
  output logic [ACC_W-1:0] acc_out,
  output logic [LED_W-1:0] led_out,
  output logic             overflow,
  output logic             acc_pulse
);

  logic [SW_W-1:0]  r_sw_s1;
  logic [SW_W-1:0]  r_sw_s2;
  logic             r_acc_key_s1;
  logic             r_acc_key_s2;
  logic             r_clr_key_s1;
  logic             r_clr_key_s2;

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_pulse;

  logic             w_acc_fire;
  logic             w_clr_fire;
  logic [ACC_W-1:0] w_operand;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_diff;
  logic [ACC_W-1:0] w_result;
  logic             w_carry;

  // Two-flop synchronisers; keys reset to their released (high) level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sw_s1      <= '0;
      r_sw_s2      <= '0;
      r_acc_key_s1 <= 1'b1;
      r_acc_key_s2 <= 1'b1;
      r_clr_key_s1 <= 1'b1;
      r_clr_key_s2 <= 1'b1;
    end else begin
      r_sw_s1      <= sw_in;
      r_sw_s2      <= r_sw_s1;
      r_acc_key_s1 <= acc_key_n;
      r_acc_key_s2 <= r_acc_key_s1;
      r_clr_key_s1 <= clr_key_n;
      r_clr_key_s2 <= r_clr_key_s1;
    end
  end

  switch_accumulator_key #(
    .DEB_CYCLES (DEB_CYCLES),
    .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD),
    .REPEAT_EN  (1'b1)
  ) u_acc_key (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_key_n (r_acc_key_s2),
    .o_fire  (w_acc_fire)
  );

  switch_accumulator_key #(
    .DEB_CYCLES (DEB_CYCLES),
    .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD),
    .REPEAT_EN  (1'b0)
  ) u_clr_key (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_key_n (r_clr_key_s2),
    .o_fire  (w_clr_fire)
  );

  // Operand is the zero-extended synced switch value; the extra MSB is carry/borrow.
  assign w_operand = ACC_W'(r_sw_s2);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_operand};
  assign w_diff    = {1'b0, r_acc} - {1'b0, w_operand};

  // Select add/subtract result and apply wrap or saturate on carry/borrow.
  always_comb begin
    w_result = r_acc;
    w_carry  = 1'b0;
    if (sub_mode) begin
      w_carry  = w_diff[ACC_W];
      w_result = (w_carry && sat_mode) ? '0 : w_diff[ACC_W-1:0];
    end else begin
      w_carry  = w_sum[ACC_W];
      w_result = (w_carry && sat_mode) ? '1 : w_sum[ACC_W-1:0];
    end
  end

  // Accumulator, sticky overflow and result strobe; clear beats a coincident fire.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_pulse <= 1'b0;
    end else if (w_clr_fire) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_pulse <= 1'b0;
    end else if (w_acc_fire) begin
      r_acc   <= w_result;
      r_pulse <= 1'b1;
      if (w_carry) r_ovf <= 1'b1;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign acc_out   = r_acc;
  assign led_out   = r_acc[LED_W-1:0];
  assign overflow  = r_ovf;
  assign acc_pulse = r_pulse;

endmodule

// File: tb/tb_switch_accumulator.sv
// Directed bench for switch_accumulator with short debounce/repeat timing.
module tb_switch_accumulator;

  localparam int SW_W       = 8;
  localparam int ACC_W      = 8;
  localparam int LED_W      = 8;
  localparam int DEB_CYCLES = 4;
  localparam int REP_DELAY  = 20;
  localparam int REP_PERIOD = 8;

  logic             clk_clk       = 1'b0;
  logic             reset_reset_n = 1'b0;
  logic [SW_W-1:0]  sw_in         = '0;
  logic             acc_key_n     = 1'b1;
  logic             clr_key_n     = 1'b1;
  logic             sub_mode      = 1'b0;
  logic             sat_mode      = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic [LED_W-1:0] led_out;
  logic             overflow;
  logic             acc_pulse;

  int n_cmp     = 0;
  int n_bad     = 0;
  int pulse_cnt = 0;

  switch_accumulator #(
    .SW_W       (SW_W),
    .ACC_W      (ACC_W),
    .LED_W      (LED_W),
    .DEB_CYCLES (DEB_CYCLES),
    .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .sw_in         (sw_in),
    .acc_key_n     (acc_key_n),
    .clr_key_n     (clr_key_n),
    .sub_mode      (sub_mode),
    .sat_mode      (sat_mode),
    .acc_out       (acc_out),
    .led_out       (led_out),
    .overflow      (overflow),
    .acc_pulse     (acc_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  // Count strobe cycles, sampled on the falling edge.
  always @(negedge clk_clk) if (acc_pulse) pulse_cnt <= pulse_cnt + 1;

  typedef struct {
    bit         clr_first;
    logic [7:0] sw;
    bit         sub;
    bit         sat;
    logic [7:0] exp_acc;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press_acc(input int hold);
    @(negedge clk_clk);
    acc_key_n = 1'b0;
    repeat (hold) @(negedge clk_clk);
    acc_key_n = 1'b1;
    repeat (12) @(negedge clk_clk);
    #1;
  endtask

  task automatic press_clr();
    @(negedge clk_clk);
    clr_key_n = 1'b0;
    repeat (10) @(negedge clk_clk);
    clr_key_n = 1'b1;
    repeat (12) @(negedge clk_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int fire_edge;
    int got_off[$];
    int exp_off[5];

    //             clr   sw     sub   sat   acc    ovf
    vecs[0]  = '{1'b1, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0};
    vecs[1]  = '{1'b0, 8'h03, 1'b0, 1'b0, 8'h01, 1'b1};
    vecs[2]  = '{1'b1, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0};
    vecs[3]  = '{1'b0, 8'h03, 1'b0, 1'b1, 8'hFF, 1'b1};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0};
    vecs[5]  = '{1'b0, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0};
    vecs[7]  = '{1'b0, 8'h05, 1'b1, 1'b0, 8'hFD, 1'b1};
    vecs[8]  = '{1'b0, 8'h0A, 1'b0, 1'b0, 8'h07, 1'b1};
    vecs[9]  = '{1'b0, 8'h01, 1'b1, 1'b0, 8'h06, 1'b1};
    vecs[10] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    exp_off = '{20, 28, 36, 44, 52};

    // Reset state.
    repeat (3) @(negedge clk_clk);
    #1;
    check("rst_acc", acc_out, 0);
    check("rst_led", led_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pulse", acc_pulse, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);

    // Test 1: single press, latency and strobe.
    sw_in     = 8'h05;
    p0        = pulse_cnt;
    fire_edge = 0;
    acc_key_n = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk_clk);
      #1;
      if (fire_edge == 0 && acc_out != 8'h00) begin
        fire_edge = e;
        check("t1_pulse_with_update", acc_pulse, 1);
      end
      if (e == 10) acc_key_n = 1'b1;
    end
    check("t1_latency_edges", fire_edge, DEB_CYCLES + 3);
    repeat (12) @(negedge clk_clk);
    #1;
    check("t1_acc", acc_out, 8'h05);
    check("t1_led", led_out, 8'h05);
    check("t1_ovf", overflow, 0);
    check("t1_pulse_count", pulse_cnt - p0, 1);

    // Test 2: bouncy press never completes the debounce.
    p0 = pulse_cnt;
    @(negedge clk_clk);
    acc_key_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    acc_key_n = 1'b1;
    repeat (1) @(negedge clk_clk);
    acc_key_n = 1'b0;
    repeat (2) @(negedge clk_clk);
    acc_key_n = 1'b1;
    repeat (20) @(negedge clk_clk);
    #1;
    check("t2_acc_unchanged", acc_out, 8'h05);
    check("t2_no_pulse", pulse_cnt - p0, 0);

    // Tests 3/4: arithmetic table.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].clr_first) begin
        press_clr();
        check($sformatf("vec%0d_clear_acc", i), acc_out, 0);
      end
      sw_in    = vecs[i].sw;
      sub_mode = vecs[i].sub;
      sat_mode = vecs[i].sat;
      p0       = pulse_cnt;
      press_acc(10);
      check($sformatf("vec%0d_acc", i), acc_out, vecs[i].exp_acc);
      check($sformatf("vec%0d_led", i), led_out, vecs[i].exp_acc);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
      check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, 1);
    end

    // Test 5: auto-repeat and release bounce.
    press_clr();
    sw_in     = 8'h01;
    sub_mode  = 1'b0;
    sat_mode  = 1'b0;
    p0        = pulse_cnt;
    fire_edge = 0;
    acc_key_n = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk_clk);
      #1;
      if (acc_pulse) begin
        fire_edge = e;
        break;
      end
    end
    check("t5_first_fire_edge", fire_edge, DEB_CYCLES + 3);
    for (int j = 1; j <= 54; j++) begin
      @(posedge clk_clk);
      #1;
      if (acc_pulse) got_off.push_back(j);
    end
    acc_key_n = 1'b1;
    check("t5_repeat_count", got_off.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("t5_repeat_offset%0d", k), (k < got_off.size()) ? got_off[k] : -1, exp_off[k]);
    repeat (2) @(negedge clk_clk);
    acc_key_n = 1'b0;
    repeat (2) @(negedge clk_clk);
    acc_key_n = 1'b1;
    repeat (20) @(negedge clk_clk);
    #1;
    check("t5_acc", acc_out, 8'h06);
    check("t5_total_pulses", pulse_cnt - p0, 6);

    // Test 6a: clear and fire on the same cycle.
    sw_in = 8'hFF;
    press_acc(10);
    check("t6_pre_acc", acc_out, 8'h05);
    check("t6_pre_ovf", overflow, 1);
    p0 = pulse_cnt;
    @(negedge clk_clk);
    acc_key_n = 1'b0;
    clr_key_n = 1'b0;
    repeat (10) @(negedge clk_clk);
    acc_key_n = 1'b1;
    clr_key_n = 1'b1;
    repeat (12) @(negedge clk_clk);
    #1;
    check("t6_clr_wins_acc", acc_out, 0);
    check("t6_clr_wins_ovf", overflow, 0);
    check("t6_clr_wins_pulse", pulse_cnt - p0, 0);

    // Test 6b: reset during REPEAT with the key still held.
    sw_in = 8'h03;
    @(negedge clk_clk);
    acc_key_n = 1'b0;
    repeat (40) @(negedge clk_clk);
    #1;
    check("t6_repeat_acc", acc_out, 8'h09);
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    check("t6_rst_acc", acc_out, 0);
    check("t6_rst_led", led_out, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_pulse", acc_pulse, 0);
    repeat (2) @(negedge clk_clk);
    p0            = pulse_cnt;
    fire_edge     = 0;
    reset_reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk_clk);
      #1;
      if (fire_edge == 0 && acc_pulse) fire_edge = e;
    end
    acc_key_n = 1'b1;
    check("t6_post_rst_fire_edge", fire_edge, DEB_CYCLES + 3);
    repeat (15) @(negedge clk_clk);
    #1;
    check("t6_post_rst_acc", acc_out, 8'h03);
    check("t6_post_rst_pulses", pulse_cnt - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
